// File: rtl/stream_pkg.sv
// Shared types and constants for the stream Wishbone slave and its FIFO.
package stream_pkg;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } stream_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        END   = 2'd2
    } burst_state_t;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    // Byte-reverse the data word and bit-reverse the byte enables; address untouched.
    function automatic stream_entry_t swap_entry(stream_entry_t e);
        stream_entry_t r;
        r.adr = e.adr;
        r.dat = {e.dat[7:0], e.dat[15:8], e.dat[23:16], e.dat[31:24]};
        r.sel = {e.sel[0], e.sel[1], e.sel[2], e.sel[3]};
        return r;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle with master/slave views.
interface wshb_if #(
    parameter int DATA_BYTES = 4
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [31:0]             adr;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic [DATA_BYTES-1:0]   sel;
    logic                    ack;
    logic                    err;
    logic                    rty;
    logic [2:0]              cti;
    logic [1:0]              bte;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, err, rty, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, err, rty, dat_sm
    );
endinterface

// File: rtl/stream_fifo.sv
// Show-ahead FIFO of stream entries. DEPTH must be a power of two so the
// pointers wrap naturally. dout_next exposes the entry behind the head so the
// burst logic can look one word ahead.
module stream_fifo
    import stream_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  stream_entry_t          din,
    output stream_entry_t          dout,
    output stream_entry_t          dout_next,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    stream_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_next;
    logic          do_push;
    logic          do_pop;

    assign full        = (level == (AW+1)'(DEPTH));
    assign empty       = (level == '0);
    assign do_push     = push & ~full;
    assign do_pop      = pop & ~empty;
    assign rd_ptr_next = rd_ptr + 1'b1;
    assign dout        = mem[rd_ptr];
    assign dout_next   = mem[rd_ptr_next];

    // Pointer and occupancy bookkeeping; full/empty come from the pre-edge level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr_next;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/stream_wshb_slave.sv
// Wishbone stream slave that buffers write words and replays them as
// incrementing bursts on a Wishbone master port toward SDRAM.
// Optional build macro STREAM_BYTE_SWAP_EN: byte-reverse data and
// bit-reverse sel as words enter the FIFO.
module stream_wshb_slave
    import stream_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int BURST_LEN     = 8,
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    wshb_if.slave                       wshb_ifs,
    wshb_if.master                      wshb_ifm,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_BURST = BURST;
    localparam logic [1:0] ST_END   = END;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    stream_entry_t din;
    stream_entry_t head;
    stream_entry_t head_next;

    logic [1:0]    state;
    logic [BW-1:0] beat_cnt;
    logic [TW-1:0] idle_tmr;
    logic          busy;
    logic          last;
    logic [31:0]   next_adr;

    // ---------------- slave side ----------------
    assign push            = wshb_ifs.cyc & wshb_ifs.stb & wshb_ifs.we & ~full;
    assign wshb_ifs.ack    = push;
    assign wshb_ifs.err    = wshb_ifs.cyc & wshb_ifs.stb & ~wshb_ifs.we;
    assign wshb_ifs.rty    = 1'b0;
    assign wshb_ifs.dat_sm = '0;

    stream_entry_t raw_entry;
    assign raw_entry.adr = wshb_ifs.adr;
    assign raw_entry.dat = wshb_ifs.dat_ms;
    assign raw_entry.sel = wshb_ifs.sel;

`ifdef STREAM_BYTE_SWAP_EN
    assign din = swap_entry(raw_entry);
`else
    assign din = raw_entry;
`endif

    stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .dout      (head),
        .dout_next (head_next),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    // ---------------- master side ----------------
    assign busy     = (state == ST_BURST);
    assign pop      = busy & wshb_ifm.ack;
    assign next_adr = head.adr + 32'd4;

    // The top-of-address check catches the 32-bit wrap, which must end a burst.
    assign last = (beat_cnt == BW'(BURST_LEN - 1))
                | (fifo_level == LW'(1))
                | (head.adr == 32'hFFFF_FFFC)
                | (head_next.adr != next_adr);

    assign wshb_ifm.cyc    = busy;
    assign wshb_ifm.stb    = busy;
    assign wshb_ifm.we     = busy;
    assign wshb_ifm.adr    = busy ? head.adr : '0;
    assign wshb_ifm.dat_ms = busy ? head.dat : '0;
    assign wshb_ifm.sel    = busy ? head.sel : '0;
    assign wshb_ifm.cti    = busy ? (last ? CTI_EOB : CTI_INCR) : 3'b000;
    assign wshb_ifm.bte    = 2'b00;

    // Burst sequencer: flush timer is a down-counter reloaded after every burst.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            idle_tmr <= TW'(FLUSH_TIMEOUT);
        end else begin
            case (state)
                ST_IDLE: begin
                    beat_cnt <= '0;
                    if (!empty) begin
                        if (fifo_level >= LW'(BURST_LEN) || idle_tmr == TW'(1))
                            state <= ST_BURST;
                        else
                            idle_tmr <= idle_tmr - 1'b1;
                    end
                end
                ST_BURST: begin
                    if (wshb_ifm.ack) begin
                        if (last) state <= ST_END;
                        else      beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                ST_END: begin
                    state    <= ST_IDLE;
                    beat_cnt <= '0;
                    idle_tmr <= TW'(FLUSH_TIMEOUT);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic unused_bus;
    assign unused_bus = ^{wshb_ifm.err, wshb_ifm.rty, wshb_ifm.dat_sm,
                          wshb_ifs.cti, wshb_ifs.bte};

endmodule

// File: tb/tb_stream_wshb_slave.sv
// Bench for stream_wshb_slave: queue-based reference of the buffered words
// and the burst-boundary rules, mixed directed and randomized traffic.
module tb_stream_wshb_slave;
    import stream_pkg::*;

    localparam int DEPTH = 16;
    localparam int BLEN  = 8;
    localparam int TMO   = 64;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [4:0] fifo_level;

    wshb_if #(.DATA_BYTES(4)) ifs_bus ();
    wshb_if #(.DATA_BYTES(4)) ifm_bus ();

    stream_wshb_slave #(
        .FIFO_DEPTH    (DEPTH),
        .BURST_LEN     (BLEN),
        .FLUSH_TIMEOUT (TMO)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wshb_ifs   (ifs_bus),
        .wshb_ifm   (ifm_bus),
        .fifo_level (fifo_level)
    );

    always #5 sys_clk = ~sys_clk;

    int            n_chk      = 0;
    int            n_err      = 0;
    int            cyc_no     = 0;
    int            accept_cyc = -1;
    int            beats      = 0;
    int            ack_mode   = 1;
    bit            end_pending = 1'b0;
    bit            rd_req     = 1'b0;
    stream_entry_t mq[$];
    stream_entry_t offer[$];

    task automatic check_val(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    function automatic stream_entry_t expect_entry(stream_entry_t e);
        stream_entry_t r;
        r = e;
`ifdef STREAM_BYTE_SWAP_EN
        r.dat = {e.dat[7:0], e.dat[15:8], e.dat[23:16], e.dat[31:24]};
        for (int i = 0; i < 4; i++) r.sel[i] = e.sel[3-i];
`endif
        return r;
    endfunction

    task automatic offer_word(logic [31:0] a, logic [31:0] d, logic [3:0] s);
        stream_entry_t e;
        e.adr = a;
        e.dat = d;
        e.sel = s;
        offer.push_back(e);
    endtask

    // One bus cycle: drive at the falling edge, sample just after, update the model.
    task automatic step();
        bit            exp_ack;
        bit            exp_last;
        bit            m_ack;
        stream_entry_t h;
        @(negedge sys_clk);
        cyc_no++;
        if (offer.size() > 0) begin
            ifs_bus.cyc    = 1'b1;
            ifs_bus.stb    = 1'b1;
            ifs_bus.we     = 1'b1;
            ifs_bus.adr    = offer[0].adr;
            ifs_bus.dat_ms = offer[0].dat;
            ifs_bus.sel    = offer[0].sel;
        end else if (rd_req) begin
            ifs_bus.cyc = 1'b1;
            ifs_bus.stb = 1'b1;
            ifs_bus.we  = 1'b0;
            ifs_bus.adr = $urandom & 32'hFFFF_FFFC;
        end else begin
            ifs_bus.cyc = 1'b0;
            ifs_bus.stb = 1'b0;
            ifs_bus.we  = 1'b0;
        end
        #1;
        exp_ack = (offer.size() > 0) && (mq.size() < DEPTH);
        check_val("s_ack", ifs_bus.ack, exp_ack);
        check_val("s_err", ifs_bus.err, (offer.size() == 0) && rd_req);
        check_val("level", fifo_level, mq.size());
        check_val("stb_when_empty", ifm_bus.stb && (mq.size() == 0), 0);
        if (end_pending) begin
            check_val("end_gap", ifm_bus.cyc, 0);
            end_pending = 1'b0;
        end
        m_ack = 1'b0;
        if (ifm_bus.stb && mq.size() > 0) begin
            h = mq[0];
            check_val("m_adr", ifm_bus.adr, h.adr);
            check_val("m_dat", ifm_bus.dat_ms, h.dat);
            check_val("m_sel", ifm_bus.sel, h.sel);
            check_val("m_we", ifm_bus.we, 1);
            check_val("m_bte", ifm_bus.bte, 0);
            exp_last = (beats == BLEN - 1) || (mq.size() == 1) ||
                       (h.adr == 32'hFFFF_FFFC) || (mq[1].adr != h.adr + 32'd4);
            check_val("m_cti", ifm_bus.cti, exp_last ? 3'b111 : 3'b010);
            case (ack_mode)
                1:       m_ack = 1'b1;
                2:       m_ack = ($urandom_range(0, 1) == 1);
                default: m_ack = 1'b0;
            endcase
            if (m_ack) begin
                void'(mq.pop_front());
                if (exp_last) begin
                    beats       = 0;
                    end_pending = 1'b1;
                end else begin
                    beats++;
                end
            end
        end
        ifm_bus.ack = m_ack;
        if (exp_ack) begin
            mq.push_back(expect_entry(offer[0]));
            void'(offer.pop_front());
            if (accept_cyc < 0) accept_cyc = cyc_no;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() > 0 || offer.size() > 0 || ifm_bus.cyc) && n < 2000) begin
            step();
            n++;
        end
        check_val("drain_done", n < 2000, 1);
        repeat (3) step();
    endtask

    initial begin
        logic [31:0] nxt;
        int          r;
        int          n;

        ifs_bus.cyc = 1'b0;  ifs_bus.stb = 1'b0;  ifs_bus.we  = 1'b0;
        ifs_bus.adr = '0;    ifs_bus.dat_ms = '0; ifs_bus.sel = '0;
        ifs_bus.cti = '0;    ifs_bus.bte = '0;
        ifm_bus.ack = 1'b0;  ifm_bus.err = 1'b0;  ifm_bus.rty = 1'b0;
        ifm_bus.dat_sm = '0;

        // Reset values
        #2;
        check_val("rst_m_cyc", ifm_bus.cyc, 0);
        check_val("rst_m_stb", ifm_bus.stb, 0);
        check_val("rst_m_adr", ifm_bus.adr, 0);
        check_val("rst_m_cti", ifm_bus.cti, 0);
        check_val("rst_level", fifo_level, 0);
        check_val("rst_s_ack", ifs_bus.ack, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Eight consecutive words: one full burst
        ack_mode = 1;
        for (int i = 0; i < 8; i++) offer_word(32'(i * 4), 32'(i), 4'hF);
        drain();

        // Three words then silence: flushed by the idle timer
        accept_cyc = -1;
        offer_word(32'h100, 32'hA0, 4'hF);
        offer_word(32'h104, 32'hA1, 4'hF);
        offer_word(32'h108, 32'hA2, 4'hF);
        n = 0;
        do begin
            step();
            n++;
        end while (!ifm_bus.stb && n < 300);
        check_val("flush_latency", cyc_no - accept_cyc, TMO + 1);
        drain();

        // Address discontinuity splits the burst
        offer_word(32'h200, 32'hB0, 4'hF);
        for (int i = 0; i < 8; i++) offer_word(32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 4'hF);
        drain();

        // Address wrap ends a burst
        offer_word(32'hFFFF_FFF8, 32'hD0, 4'hF);
        offer_word(32'hFFFF_FFFC, 32'hD1, 4'hF);
        offer_word(32'h0000_0000, 32'hD2, 4'hF);
        offer_word(32'h0000_0004, 32'hD3, 4'hF);
        drain();

        // Byte lane handling
        offer_word(32'h500, 32'h1122_3344, 4'b0011);
        drain();

        // Backpressure: SDRAM stalls, 17 words offered
        ack_mode = 0;
        for (int i = 0; i < 17; i++) offer_word(32'h600 + 32'(i * 4), 32'h600 + 32'(i), 4'hF);
        repeat (20) step();
        check_val("bp_level", fifo_level, 16);
        check_val("bp_stall_ack", ifs_bus.ack, 0);
        ack_mode = 1;
        drain();

        // Slave read: one-cycle error
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        step();

        // Reset in the middle of a stalled burst
        ack_mode = 0;
        for (int i = 0; i < 10; i++) offer_word(32'h800 + 32'(i * 4), $urandom, 4'hF);
        repeat (14) step();
        check_val("pre_rst_cyc", ifm_bus.cyc, 1);
        @(negedge sys_clk);
        ifs_bus.cyc = 1'b0; ifs_bus.stb = 1'b0; ifs_bus.we = 1'b0;
        ifm_bus.ack = 1'b0;
        sys_rst = 1'b1;
        #1;
        check_val("rst_mid_cyc", ifm_bus.cyc, 0);
        check_val("rst_mid_stb", ifm_bus.stb, 0);
        check_val("rst_mid_level", fifo_level, 0);
        check_val("rst_mid_adr", ifm_bus.adr, 0);
        mq.delete();
        offer.delete();
        beats       = 0;
        end_pending = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Randomized traffic with random SDRAM acknowledge
        ack_mode = 2;
        nxt = 32'h4000;
        repeat (600) begin
            if (offer.size() == 0 && $urandom_range(0, 3) != 0) begin
                r = $urandom_range(0, 9);
                if (r == 0)      nxt = $urandom & 32'hFFFF_FFFC;
                else if (r == 1) nxt = 32'hFFFF_FFF4;
                offer_word(nxt, $urandom, 4'($urandom));
                nxt = nxt + 32'd4;
            end
            rd_req = (offer.size() == 0) && ($urandom_range(0, 15) == 0);
            step();
            rd_req = 1'b0;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
